// File: rtl/sipo_stream_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
//   Shared constants and helpers for the sipo_stream deserialiser.
//   - LSB_FIRST_ORDER / MSB_FIRST_ORDER : values for the MSB_FIRST parameter
//   - fill_width(w)                     : width of the fill counter for a
//                                         w-bit word (never less than 1)
// ---------------------------------------------------------------------------
package sipo_pkg;

  localparam int LSB_FIRST_ORDER = 0;
  localparam int MSB_FIRST_ORDER = 1;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

  // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int fill_width(input int w);
    int cw;
    cw = $clog2(w);
    if (cw < 1) begin
      cw = 1;
    end
    return cw;
  endfunction

endpackage : sipo_pkg

// File: rtl/sipo_stream_if.sv
// ---------------------------------------------------------------------------
// sipo_stream_if
//   Bundles the serial input side, the parallel output handshake and the
//   status outputs of sipo_stream.
//   Signals:
//     clear      synchronous flush request
//     ser_in     serial data bit
//     ser_valid  ser_in valid this cycle
//     ser_ready  deserialiser accepts a bit this cycle
//     par_out    assembled parallel word (WIDTH bits)
//     par_valid  par_out holds an unconsumed word
//     par_ready  downstream consumes par_out this cycle
//     fill       bits held in the current partial word (CW bits)
//     overrun    sticky: an unconsumed word was overwritten
//   Modports:
//     slave  : the deserialiser's view
//     master : the view of the logic driving the link and consuming words
// ---------------------------------------------------------------------------
interface sipo_stream_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = fill_width(WIDTH)
);

  logic             clear;
  logic             ser_in;
  logic             ser_valid;
  logic             ser_ready;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             par_ready;
  logic [CW-1:0]    fill;
  logic             overrun;

  modport slave (
    input  clear,
    input  ser_in,
    input  ser_valid,
    input  par_ready,
    output ser_ready,
    output par_out,
    output par_valid,
    output fill,
    output overrun
  );

  modport master (
    output clear,
    output ser_in,
    output ser_valid,
    output par_ready,
    input  ser_ready,
    input  par_out,
    input  par_valid,
    input  fill,
    input  overrun
  );

endinterface : sipo_stream_if

// File: rtl/sipo_stream_shift_core.sv
// ---------------------------------------------------------------------------
// sipo_shift_core
//   Shift register plus fill counter that frames serial bits into words.
//   Ports:
//     clk          rising-edge clock
//     rst_n        synchronous active-low reset
//     clear_i      synchronous flush of the partial word (beats acc_i)
//     acc_i        a bit is accepted this cycle
//     bit_i        the accepted bit
//     word_done_o  this accept completes a word
//     word_o       the completed word (current bit included); only
//                  meaningful while word_done_o is high
//     fill_o       bits held in the partial word, 0..WIDTH-1
// ---------------------------------------------------------------------------
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = LSB_FIRST_ORDER,
  parameter int CW        = fill_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             acc_i,
  input  logic             bit_i,
  output logic             word_done_o,
  output logic [WIDTH-1:0] word_o,
  output logic [CW-1:0]    fill_o
);

  // Only WIDTH-1 bits are stored: the bit that completes a word is taken
  // straight from bit_i, so a full-width register would hold a bit that
  // is never read before it is shifted out.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CW-1:0]    fill_q,  fill_d;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  generate
    if (MSB_FIRST == MSB_FIRST_ORDER) begin : g_msb_first
      // Older bits move towards the MSB; the first bit ends in bit WIDTH-1.
      assign shifted = {shreg_q, bit_i};
    end else begin : g_lsb_first
      // Older bits move towards the LSB; the first bit ends in bit 0.
      assign shifted = {bit_i, shreg_q};
    end
  endgenerate

  assign last_bit    = (fill_q == CW'(WIDTH - 1));
  assign word_done_o = acc_i && last_bit && !clear_i;
  assign word_o      = shifted;
  assign fill_o      = fill_q;

  always_comb begin
    shreg_d = shreg_q;
    fill_d  = fill_q;
    if (clear_i) begin
      shreg_d = '0;
      fill_d  = '0;
    end else if (acc_i) begin
      if (MSB_FIRST == MSB_FIRST_ORDER) begin
        shreg_d = shifted[WIDTH-2:0];
      end else begin
        shreg_d = shifted[WIDTH-1:1];
      end
      fill_d = last_bit ? '0 : fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q <= '0;
      fill_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
    end
  end

endmodule : sipo_shift_core

// File: rtl/sipo_stream.sv
// ---------------------------------------------------------------------------
// sipo_stream
//   Parametrised serial-in/parallel-out deserialiser with a registered
//   parallel output, valid/ready handshake and either backpressure towards
//   the serial side or overwrite-with-overrun-flag behaviour.
//   Parameters:
//     WIDTH         word width, 2..64
//     MSB_FIRST     0: first bit -> par_out[0]; 1: first bit -> par_out[WIDTH-1]
//     BACKPRESSURE  1: stall serial side when output full; 0: overwrite
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset (beats every other input)
//     bus    sipo_stream_if.slave: clear, ser_in/ser_valid/ser_ready,
//            par_out/par_valid/par_ready, fill, overrun
// ---------------------------------------------------------------------------
module sipo_stream
  import sipo_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MSB_FIRST    = LSB_FIRST_ORDER,
  parameter int BACKPRESSURE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  sipo_stream_if.slave bus
);

  localparam int CW = fill_width(WIDTH);

  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("sipo_stream: WIDTH must lie in 2..64");
    end
  endgenerate

  logic             acc;
  logic             ser_ready;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    fill;
  logic             fill_last;

  logic [WIDTH-1:0] par_out_q,   par_out_d;
  logic             par_valid_q, par_valid_d;
  logic             overrun_q,   overrun_d;

  assign fill_last = (fill == CW'(WIDTH - 1));

  generate
    if (BACKPRESSURE != 0) begin : g_backpressure
      // Only the word-completing bit can be refused; par_ready feeds this
      // combinationally so a drain in the same cycle lets the bit through.
      assign ser_ready = !(fill_last && par_valid_q && !bus.par_ready);
    end else begin : g_overwrite
      assign ser_ready = 1'b1;
    end
  endgenerate

  assign acc = bus.ser_valid && ser_ready;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (bus.clear),
    .acc_i       (acc),
    .bit_i       (bus.ser_in),
    .word_done_o (word_done),
    .word_o      (word),
    .fill_o      (fill)
  );

  // Output register: clear beats a completion, a completion beats a drain.
  // A completion coinciding with a drain simply replaces the word.
  always_comb begin
    par_out_d   = par_out_q;
    par_valid_d = par_valid_q;
    overrun_d   = overrun_q;
    if (bus.clear) begin
      par_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else if (word_done) begin
      par_out_d   = word;
      par_valid_d = 1'b1;
      if ((BACKPRESSURE == 0) && par_valid_q && !bus.par_ready) begin
        overrun_d = 1'b1;
      end
    end else if (par_valid_q && bus.par_ready) begin
      par_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.ser_ready = ser_ready;
  assign bus.par_out   = par_out_q;
  assign bus.par_valid = par_valid_q;
  assign bus.fill      = fill;
  assign bus.overrun   = overrun_q;

endmodule : sipo_stream

// File: tb/tb_sipo_stream.sv
// ---------------------------------------------------------------------------
// tb_sipo_stream
//   Three deserialiser configurations share one stimulus stream:
//     u0: WIDTH=4, LSB first, backpressure
//     u1: WIDTH=8, MSB first, backpressure
//     u2: WIDTH=4, LSB first, overwrite/overrun
//   A word-level model per instance places each accepted bit at its final
//   position by index and is compared against every output each cycle.
// ---------------------------------------------------------------------------
module tb_sipo_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic sv    = 1'b0;
  logic sb    = 1'b0;
  logic pr    = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  sipo_stream_if #(.WIDTH(4)) if0 ();
  sipo_stream_if #(.WIDTH(8)) if1 ();
  sipo_stream_if #(.WIDTH(4)) if2 ();

  assign if0.clear = clear; assign if0.ser_in = sb; assign if0.ser_valid = sv; assign if0.par_ready = pr;
  assign if1.clear = clear; assign if1.ser_in = sb; assign if1.ser_valid = sv; assign if1.par_ready = pr;
  assign if2.clear = clear; assign if2.ser_in = sb; assign if2.ser_valid = sv; assign if2.par_ready = pr;

  sipo_stream #(.WIDTH(4), .MSB_FIRST(0), .BACKPRESSURE(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sipo_stream #(.WIDTH(8), .MSB_FIRST(1), .BACKPRESSURE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  sipo_stream #(.WIDTH(4), .MSB_FIRST(0), .BACKPRESSURE(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] part;
    int          cnt;
    logic [63:0] out;
    bit          vld;
    bit          ovr;
  } mst_t;

  mst_t m0, m1, m2;

  function automatic bit mready(mst_t s, int w, bit bp, bit p);
    if (!bp) return 1'b1;
    return !(s.cnt == w - 1 && s.vld && !p);
  endfunction

  function automatic mst_t mstep(mst_t s, int w, bit msb, bit bp,
                                 bit rn, bit clr, bit v, bit b, bit p);
    mst_t n;
    bit   done;
    n = s;
    if (!rn) begin
      n.part = '0; n.cnt = 0; n.out = '0; n.vld = 1'b0; n.ovr = 1'b0;
      return n;
    end
    if (clr) begin
      n.part = '0; n.cnt = 0; n.vld = 1'b0; n.ovr = 1'b0;
      return n;
    end
    done = 1'b0;
    if (v && mready(s, w, bp, p)) begin
      if (msb) n.part[w - 1 - s.cnt] = b;
      else     n.part[s.cnt] = b;
      n.cnt = s.cnt + 1;
      if (n.cnt == w) begin
        done   = 1'b1;
        n.out  = n.part;
        n.part = '0;
        n.cnt  = 0;
      end
    end
    if (done) begin
      if (s.vld && !p) n.ovr = 1'b1;
      n.vld = 1'b1;
    end else if (s.vld && p) begin
      n.vld = 1'b0;
    end
    return n;
  endfunction

  initial begin
    m0 = '{default: '0};
    m1 = '{default: '0};
    m2 = '{default: '0};
  end

  always @(posedge clk) begin
    m0 = mstep(m0, 4, 1'b0, 1'b1, rst_n, clear, sv, sb, pr);
    m1 = mstep(m1, 8, 1'b1, 1'b1, rst_n, clear, sv, sb, pr);
    m2 = mstep(m2, 4, 1'b0, 1'b0, rst_n, clear, sv, sb, pr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0.par_out",   if0.par_out,   m0.out[3:0]);
      chk("u0.par_valid", if0.par_valid, m0.vld);
      chk("u0.fill",      if0.fill,      m0.cnt);
      chk("u0.overrun",   if0.overrun,   m0.ovr);
      chk("u0.ser_ready", if0.ser_ready, mready(m0, 4, 1'b1, pr));
      chk("u1.par_out",   if1.par_out,   m1.out[7:0]);
      chk("u1.par_valid", if1.par_valid, m1.vld);
      chk("u1.fill",      if1.fill,      m1.cnt);
      chk("u1.overrun",   if1.overrun,   m1.ovr);
      chk("u1.ser_ready", if1.ser_ready, mready(m1, 8, 1'b1, pr));
      chk("u2.par_out",   if2.par_out,   m2.out[3:0]);
      chk("u2.par_valid", if2.par_valid, m2.vld);
      chk("u2.fill",      if2.fill,      m2.cnt);
      chk("u2.overrun",   if2.overrun,   m2.ovr);
      chk("u2.ser_ready", if2.ser_ready, mready(m2, 4, 1'b0, pr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sv = 1'b0; clear = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input bit b);
    sv = 1'b1; sb = b;
    tick();
  endtask

  initial begin
    logic [7:0] a5;
    do_reset();
    tick();
    chk_en = 1'b1;

    // reset state
    chk("rst.par_out",   if0.par_out,   64'h0);
    chk("rst.par_valid", if0.par_valid, 64'h0);
    chk("rst.fill",      if0.fill,      64'h0);
    chk("rst.overrun",   if2.overrun,   64'h0);

    // basic LSB-first word 1,0,1,1 -> 4'b1101
    pr = 1'b1;
    send(1'b1); chk("basic.fill1", if0.fill, 64'd1);
    send(1'b0); chk("basic.fill2", if0.fill, 64'd2);
    send(1'b1); chk("basic.fill3", if0.fill, 64'd3);
    chk("basic.not_yet_valid", if0.par_valid, 64'h0);
    send(1'b1); chk("basic.fill0", if0.fill, 64'd0);
    chk("basic.par_out",   if0.par_out,   64'hD);
    chk("basic.par_valid", if0.par_valid, 64'h1);
    chk("basic.model_out", m0.out,        64'hD);
    sv = 1'b0; tick();
    chk("basic.drained", if0.par_valid, 64'h0);

    // MSB-first 8'hA5
    do_reset();
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) send(a5[i]);
    chk("msb.par_out",   if1.par_out,   64'hA5);
    chk("msb.par_valid", if1.par_valid, 64'h1);
    chk("msb.model_out", m1.out,        64'hA5);
    sv = 1'b0; tick();

    // backpressure: 0x3 then 0x5 with par_ready low
    do_reset();
    pr = 1'b0;
    send(1'b1); send(1'b1); send(1'b0); send(1'b0);
    send(1'b1); send(1'b0); send(1'b1);
    chk("bp.fill3", if0.fill, 64'd3);
    sv = 1'b1; sb = 1'b0; #1;
    chk("bp.stalled", if0.ser_ready, 64'h0);
    tick(); tick();
    chk("bp.held_out", if0.par_out, 64'h3);
    chk("bp.held_fill", if0.fill, 64'd3);
    chk("bp.still_stalled", if0.ser_ready, 64'h0);
    pr = 1'b1; #1;
    chk("bp.released", if0.ser_ready, 64'h1);
    tick();
    chk("bp.second_out",   if0.par_out,   64'h5);
    chk("bp.second_valid", if0.par_valid, 64'h1);
    sv = 1'b0; tick();
    chk("bp.drained", if0.par_valid, 64'h0);

    // overrun: 0x9 then 0x6 with par_ready low
    do_reset();
    pr = 1'b0;
    send(1'b1); send(1'b0); send(1'b0); send(1'b1);
    send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    chk("ovr.par_out", if2.par_out, 64'h6);
    chk("ovr.flag",    if2.overrun, 64'h1);
    sv = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    chk("ovr.clr_flag",  if2.overrun,   64'h0);
    chk("ovr.clr_valid", if2.par_valid, 64'h0);
    chk("ovr.clr_keep",  if2.par_out,   64'h6);

    // completion of 0xC in the cycle 0x2 drains
    do_reset();
    pr = 1'b0;
    send(1'b0); send(1'b1); send(1'b0); send(1'b0);
    send(1'b0); send(1'b0); send(1'b1);
    pr = 1'b1;
    send(1'b1);
    chk("sim.par_out",   if0.par_out,   64'hC);
    chk("sim.par_valid", if0.par_valid, 64'h1);
    chk("sim.overrun",   if2.overrun,   64'h0);
    chk("sim.u2_out",    if2.par_out,   64'hC);
    sv = 1'b0; tick();

    // reset mid-word
    pr = 1'b1;
    send(1'b1); send(1'b1);
    rst_n = 1'b0; sv = 1'b1; sb = 1'b1; tick(); rst_n = 1'b1;
    chk("rmid.fill",    if0.fill,      64'd0);
    chk("rmid.par_out", if0.par_out,   64'h0);
    chk("rmid.valid",   if0.par_valid, 64'h0);
    send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    chk("rmid.word", if0.par_out, 64'h6);

    // clear mid-word with a bit presented
    send(1'b1); send(1'b1);
    clear = 1'b1; sv = 1'b1; sb = 1'b1; tick(); clear = 1'b0;
    chk("cmid.fill", if0.fill, 64'd0);
    send(1'b1); send(1'b0); send(1'b0); send(1'b0);
    chk("cmid.word", if0.par_out, 64'h1);
    sv = 1'b0; tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sv    = ($urandom_range(0, 3) != 0);
      sb    = 1'($urandom_range(0, 1));
      pr    = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 249) != 0);
      tick();
    end
    rst_n = 1'b1; clear = 1'b0; sv = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sipo_stream
